dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: width of every address port.
REQ-002 Parameter STARVE_LIMIT, default 8: number of consecutive denied device-request cycles that forces a device grant; legal range 1..255.
REQ-003 Reset rst is asynchronous and active-high; the clock is clk.
REQ-004 Ports (name, direction, width, meaning):
 clk  in  1  clock
 rst  in  1  async active-high reset
 cpu_ren  in  1  CPU read request
 cpu_wen  in  1  CPU write request
 cpu_byt  in  1  CPU byte access
 cpu_addr  in  ADDR_WIDTH  CPU address
 cpu_wdata  in  16  CPU write data
 cpu_rdata  out  16  CPU read data
 cpu_stall  out  1  CPU access not serviced this cycle; CPU holds its request
 dev_req  in  1  device request; held until granted
 dev_we  in  1  device write (1) or read (0)
 dev_byt  in  1  device byte access
 dev_addr  in  ADDR_WIDTH  device address
 dev_wdata  in  16  device write data
 dev_gnt  out  1  device access issued this cycle
 dev_rvalid  out  1  device read data valid
 dev_rdata  out  16  device read data
 mem_ren  out  1  memory read enable
 mem_wen  out  1  memory write enable
 mem_byt  out  1  memory byte access
 mem_addr  out  ADDR_WIDTH  memory address
 mem_wdata  out  16  memory write data
 mem_rdata  in  16  memory read data, synchronous, valid the cycle after mem_ren

Function
REQ-005 The memory port carries at most one access per cycle; mem_ren and mem_wen are never both 1.
REQ-006 The CPU request is active when cpu_ren|cpu_wen. If both are 1, the access is a write.
REQ-007 Normal priority: an active CPU request owns the memory port. The device is granted only when the CPU is idle and dev_req=1.
REQ-008 Forced grant: when starve_cnt==STARVE_LIMIT and dev_req=1, the device owns the port. In that cycle cpu_stall=1 and no CPU access is issued.
REQ-009 cpu_stall=1 only in a forced-grant cycle with an active CPU request. Otherwise cpu_stall=0.
REQ-010 starve_cnt is an 8-bit register:
 - increments when dev_req & ~dev_gnt, saturating at STARVE_LIMIT;
 - clears to 0 on dev_gnt or when dev_req=0.
REQ-011 dev_gnt is combinational and is 1 exactly in the cycle the device access drives the mem_* outputs.
REQ-012 mem_* outputs are a combinational mux of the owner's signals.
REQ-013 When no requester is active: mem_ren=mem_wen=0; mem_addr, mem_wdata and mem_byt are 0.
REQ-014 A one-cycle registered read-owner tag records the source of each issued read: none, CPU or device.
REQ-015 dev_rvalid=1 in the cycle after a granted device read (tag = device); dev_rdata=mem_rdata in that cycle.
REQ-016 dev_rdata=0 when dev_rvalid=0.
REQ-017 cpu_rdata=mem_rdata when the tag = CPU; otherwise cpu_rdata=0.
REQ-018 Back-to-back reads by different owners return data to the correct port every cycle, with no bubble.
REQ-019 A device write completes in its grant cycle; no write acknowledge beyond dev_gnt.
REQ-020 Byte accesses pass mem_byt and the full address unchanged; byte-lane handling is done by the memory.

Reset
REQ-021 While rst=1:
 - starve_cnt=0 and the read-owner tag = none;
 - dev_rvalid=0, dev_rdata=0, cpu_rdata=0.
REQ-022 A read issued in the cycle rst asserts returns no dev_rvalid after reset releases.
REQ-023 The first cycle after reset uses normal priority.

Verification
REQ-024 CPU-only traffic: cpu_ren at 0x0303, mem_rdata=0xDEAD next cycle -> mem_addr=0x0303 and cpu_rdata=0xDEAD one cycle later; dev_rvalid stays 0.
REQ-025 Contention, CPU idle in cycle 3: dev_req read 0x0081 while CPU writes cycles 0-2 -> dev_gnt=1 in cycle 3 only; dev_rvalid=1 in cycle 4 with dev_rdata=mem_rdata.
REQ-026 Starvation, STARVE_LIMIT=8: CPU requests every cycle and dev_req held -> dev_gnt=1 and cpu_stall=1 in cycle 8; starve_cnt=0 in cycle 9; CPU access issued in cycle 9.
REQ-027 Interleaved reads: device read in cycle N, CPU read in cycle N+1 -> dev_rdata in cycle N+1 and cpu_rdata in cycle N+2, each equal to the corresponding mem_rdata.
REQ-028 Reset mid-read: rst asserted in the cycle of a device grant -> dev_rvalid=0 throughout; starve_cnt=0 after release.
REQ-029 Simultaneous write: cpu_wen=1 with dev_req write to 0x0004 data 0x00DF -> CPU write issued first; device write with mem_wdata=0x00DF issued in the next CPU-idle cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one synchronous memory port between the CPU
// and a device. The CPU normally has priority; a starvation counter forces
// a device grant after STARVE_LIMIT consecutive denied device cycles.
// Read data is routed back to the requester using a one-cycle owner tag.
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // CPU side
    input  logic                  cpu_ren,
    input  logic                  cpu_wen,
    input  logic                  cpu_byt,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [15:0]           cpu_wdata,
    output logic [15:0]           cpu_rdata,
    output logic                  cpu_stall,
    // Device side
    input  logic                  dev_req,
    input  logic                  dev_we,
    input  logic                  dev_byt,
    input  logic [ADDR_WIDTH-1:0] dev_addr,
    input  logic [15:0]           dev_wdata,
    output logic                  dev_gnt,
    output logic                  dev_rvalid,
    output logic [15:0]           dev_rdata,
    // Memory side
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic                  mem_byt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata
);

    // Starvation threshold in the counter's own width.
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    // Source of the read issued in the previous cycle.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_DEV  = 2'd2
    } tag_t;

    logic [7:0] r_starve_cnt;
    tag_t       r_rd_tag;

    logic w_cpu_active;
    logic w_forced;
    logic w_dev_gnt;
    logic w_cpu_issue;
    logic w_cpu_read;
    logic w_dev_read;

    // A CPU write wins over a simultaneous CPU read request.
    assign w_cpu_active = cpu_ren | cpu_wen;
    assign w_forced     = dev_req && (r_starve_cnt == LIMIT);
    assign w_dev_gnt    = dev_req && (w_forced || !w_cpu_active);
    assign w_cpu_issue  = w_cpu_active && !w_forced;
    assign w_cpu_read   = w_cpu_issue && cpu_ren && !cpu_wen;
    assign w_dev_read   = w_dev_gnt && !dev_we;

    assign dev_gnt   = w_dev_gnt;
    assign cpu_stall = w_forced && w_cpu_active;

    // Memory port mux: the owner's signals, or all zeros when idle.
    always_comb begin
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_byt   = 1'b0;
        mem_addr  = '0;
        mem_wdata = 16'h0000;
        if (w_cpu_issue) begin
            mem_ren   = cpu_ren & ~cpu_wen;
            mem_wen   = cpu_wen;
            mem_byt   = cpu_byt;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_dev_gnt) begin
            mem_ren   = ~dev_we;
            mem_wen   = dev_we;
            mem_byt   = dev_byt;
            mem_addr  = dev_addr;
            mem_wdata = dev_wdata;
        end
    end

    // Count consecutive denied device cycles, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= 8'd0;
        end else if (!dev_req || w_dev_gnt) begin
            r_starve_cnt <= 8'd0;
        end else if (r_starve_cnt != LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    // Remember who issued this cycle's read so next-cycle data is routed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_tag <= TAG_NONE;
        end else if (w_cpu_read) begin
            r_rd_tag <= TAG_CPU;
        end else if (w_dev_read) begin
            r_rd_tag <= TAG_DEV;
        end else begin
            r_rd_tag <= TAG_NONE;
        end
    end

    // Read data is returned only to the port that owns the pending read.
    always_comb begin
        dev_rvalid = (r_rd_tag == TAG_DEV);
        dev_rdata  = (r_rd_tag == TAG_DEV) ? mem_rdata : 16'h0000;
        cpu_rdata  = (r_rd_tag == TAG_CPU) ? mem_rdata : 16'h0000;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_ren, cpu_wen, cpu_byt;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dev_req, dev_we, dev_byt;
    logic [15:0] dev_addr, dev_wdata;
    logic        dev_gnt, dev_rvalid;
    logic [15:0] dev_rdata;
    logic        mem_ren, mem_wen, mem_byt;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int checks;
    int errors;

    dmem_arbiter #(.ADDR_WIDTH(16), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_byt(cpu_byt),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dev_req(dev_req), .dev_we(dev_we), .dev_byt(dev_byt),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_gnt(dev_gnt), .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_byt(mem_byt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic idle_inputs();
        cpu_ren = 0; cpu_wen = 0; cpu_byt = 0; cpu_addr = 0; cpu_wdata = 0;
        dev_req = 0; dev_we = 0; dev_byt = 0; dev_addr = 0; dev_wdata = 0;
        mem_rdata = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Device read requested while reset is held.
        rst = 1; idle_inputs();
        dev_req = 1; dev_addr = 16'h0333; mem_rdata = 16'h5A5A;
        @(negedge clk);
        checks++; if (dev_rvalid !== 1'b0) begin errors++; $display("FAIL rst_dev_rvalid actual=%b expected=0", dev_rvalid); end
        checks++; if (dev_rdata !== 16'h0) begin errors++; $display("FAIL rst_dev_rdata actual=%h expected=0000", dev_rdata); end
        checks++; if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL rst_cpu_rdata actual=%h expected=0000", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_cpu_stall actual=%b expected=0", cpu_stall); end
        // First cycle after release: no stale rvalid, normal priority.
        tick();
        rst = 0; mem_rdata = 16'h1234;
        cpu_ren = 1; cpu_addr = 16'h0010; dev_req = 1; dev_addr = 16'h0333;
        @(negedge clk);
        checks++; if (dev_rvalid !== 1'b0) begin errors++; $display("FAIL rel_dev_rvalid actual=%b expected=0", dev_rvalid); end
        checks++; if (dev_rdata !== 16'h0) begin errors++; $display("FAIL rel_dev_rdata actual=%h expected=0000", dev_rdata); end
        checks++; if (dev_gnt !== 1'b0) begin errors++; $display("FAIL rel_dev_gnt actual=%b expected=0", dev_gnt); end
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL rel_mem_addr actual=%h expected=0010", mem_addr); end
        tick(); idle_inputs();
        tick();
        $display("txn reset: done");
    endtask

    task automatic test_cpu_read();
        cpu_ren = 1; cpu_addr = 16'h0303;
        @(negedge clk);
        checks++; if (mem_addr !== 16'h0303) begin errors++; $display("FAIL cpu_rd_addr actual=%h expected=0303", mem_addr); end
        checks++; if ({mem_ren, mem_wen} !== 2'b10) begin errors++; $display("FAIL cpu_rd_en actual=%b expected=10", {mem_ren, mem_wen}); end
        tick(); idle_inputs(); mem_rdata = 16'hDEAD;
        @(negedge clk);
        checks++; if (cpu_rdata !== 16'hDEAD) begin errors++; $display("FAIL cpu_rd_data actual=%h expected=dead", cpu_rdata); end
        checks++; if (dev_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_rd_dev_rvalid actual=%b expected=0", dev_rvalid); end
        tick(); mem_rdata = 16'hDEAD;
        @(negedge clk);
        checks++; if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL cpu_rd_after actual=%h expected=0000", cpu_rdata); end
        tick(); idle_inputs();
        $display("txn cpu_read: addr=0303 data=dead");
    endtask

    task automatic test_contention();
        dev_req = 1; dev_we = 0; dev_addr = 16'h0081;
        for (int i = 0; i < 3; i++) begin
            cpu_wen = 1; cpu_addr = 16'h0010 + 16'(i); cpu_wdata = 16'h0100 + 16'(i);
            @(negedge clk);
            checks++; if (dev_gnt !== 1'b0) begin errors++; $display("FAIL cont_gnt_c%0d actual=%b expected=0", i, dev_gnt); end
            checks++; if (mem_addr !== 16'h0010 + 16'(i)) begin errors++; $display("FAIL cont_addr_c%0d actual=%h expected=%h", i, mem_addr, 16'h0010 + 16'(i)); end
            tick();
        end
        cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;
        @(negedge clk);
        checks++; if (dev_gnt !== 1'b1) begin errors++; $display("FAIL cont_gnt_c3 actual=%b expected=1", dev_gnt); end
        checks++; if (mem_addr !== 16'h0081 || mem_ren !== 1'b1) begin errors++; $display("FAIL cont_dev_rd actual=%h/%b expected=0081/1", mem_addr, mem_ren); end
        tick(); dev_req = 0; mem_rdata = 16'hBEEF;
        @(negedge clk);
        checks++; if (dev_gnt !== 1'b0) begin errors++; $display("FAIL cont_gnt_c4 actual=%b expected=0", dev_gnt); end
        checks++; if (dev_rvalid !== 1'b1 || dev_rdata !== 16'hBEEF) begin errors++; $display("FAIL cont_rdata actual=%b/%h expected=1/beef", dev_rvalid, dev_rdata); end
        tick(); idle_inputs();
        $display("txn contention: dev read 0081 granted cycle 3");
    endtask

    task automatic test_starvation();
        dev_req = 1; dev_we = 1; dev_addr = 16'h0055; dev_wdata = 16'h1111;
        for (int i = 0; i < 10; i++) begin
            cpu_ren = 1; cpu_addr = 16'h0200 + 16'(i); mem_rdata = 16'h0A00 + 16'(i);
            @(negedge clk);
            if (i == 8) begin
                checks++; if (dev_gnt !== 1'b1 || cpu_stall !== 1'b1) begin errors++; $display("FAIL starve_force actual=gnt%b/stall%b expected=1/1", dev_gnt, cpu_stall); end
                checks++; if ({mem_ren, mem_wen} !== 2'b01 || mem_addr !== 16'h0055 || mem_wdata !== 16'h1111) begin errors++; $display("FAIL starve_mem actual=%b/%h/%h expected=01/0055/1111", {mem_ren, mem_wen}, mem_addr, mem_wdata); end
            end else begin
                checks++; if (dev_gnt !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL starve_c%0d actual=gnt%b/stall%b expected=0/0", i, dev_gnt, cpu_stall); end
                checks++; if (mem_ren !== 1'b1 || mem_addr !== 16'h0200 + 16'(i)) begin errors++; $display("FAIL starve_cpu_c%0d actual=%b/%h expected=1/%h", i, mem_ren, mem_addr, 16'h0200 + 16'(i)); end
            end
            if (i >= 1 && i <= 8) begin
                checks++; if (cpu_rdata !== 16'h0A00 + 16'(i)) begin errors++; $display("FAIL starve_rdata_c%0d actual=%h expected=%h", i, cpu_rdata, 16'h0A00 + 16'(i)); end
            end
            if (i == 9) begin
                checks++; if (dut.r_starve_cnt !== 8'd0) begin errors++; $display("FAIL starve_cnt_c9 actual=%0d expected=0", dut.r_starve_cnt); end
                checks++; if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL starve_rdata_c9 actual=%h expected=0000", cpu_rdata); end
            end
            tick();
        end
        idle_inputs();
        tick();
        $display("txn starvation: forced grant cycle 8");
    endtask

    task automatic test_interleaved();
        dev_req = 1; dev_we = 0; dev_addr = 16'h0100;
        @(negedge clk);
        checks++; if (dev_gnt !== 1'b1) begin errors++; $display("FAIL intl_gnt actual=%b expected=1", dev_gnt); end
        tick(); idle_inputs();
        cpu_ren = 1; cpu_addr = 16'h0200; mem_rdata = 16'h1111;
        @(negedge clk);
        checks++; if (dev_rvalid !== 1'b1 || dev_rdata !== 16'h1111) begin errors++; $display("FAIL intl_dev actual=%b/%h expected=1/1111", dev_rvalid, dev_rdata); end
        checks++; if (cpu_rdata !== 16'h0) begin errors++; $display("FAIL intl_cpu_n1 actual=%h expected=0000", cpu_rdata); end
        tick(); idle_inputs(); mem_rdata = 16'h2222;
        @(negedge clk);
        checks++; if (cpu_rdata !== 16'h2222) begin errors++; $display("FAIL intl_cpu actual=%h expected=2222", cpu_rdata); end
        checks++; if (dev_rvalid !== 1'b0 || dev_rdata !== 16'h0) begin errors++; $display("FAIL intl_dev_n2 actual=%b/%h expected=0/0000", dev_rvalid, dev_rdata); end
        tick(); idle_inputs();
        $display("txn interleaved: dev=1111 cpu=2222");
    endtask

    task automatic test_reset_mid_read();
        // Build up the starvation count, then check reset clears it at once.
        dev_req = 1; dev_we = 0; dev_addr = 16'h0077; cpu_ren = 1; cpu_addr = 16'h0300;
        tick(); tick(); tick();
        @(negedge clk);
        checks++; if (dut.r_starve_cnt !== 8'd3) begin errors++; $display("FAIL rmr_cnt_pre actual=%0d expected=3", dut.r_starve_cnt); end
        rst = 1;
        #1;
        checks++; if (dut.r_starve_cnt !== 8'd0) begin errors++; $display("FAIL rmr_cnt_async actual=%0d expected=0", dut.r_starve_cnt); end
        tick(); rst = 0;
        // Device read granted, reset asserted during that cycle.
        cpu_ren = 0; cpu_addr = 0;
        @(negedge clk);
        checks++; if (dev_gnt !== 1'b1) begin errors++; $display("FAIL rmr_gnt actual=%b expected=1", dev_gnt); end
        rst = 1;
        #1;
        checks++; if (dev_rvalid !== 1'b0) begin errors++; $display("FAIL rmr_rvalid_a actual=%b expected=0", dev_rvalid); end
        tick(); rst = 0; idle_inputs(); mem_rdata = 16'hCAFE;
        @(negedge clk);
        checks++; if (dev_rvalid !== 1'b0 || dev_rdata !== 16'h0) begin errors++; $display("FAIL rmr_rvalid_b actual=%b/%h expected=0/0000", dev_rvalid, dev_rdata); end
        checks++; if (dut.r_starve_cnt !== 8'd0) begin errors++; $display("FAIL rmr_cnt_post actual=%0d expected=0", dut.r_starve_cnt); end
        tick(); idle_inputs();
        $display("txn reset_mid_read: no rvalid");
    endtask

    task automatic test_simultaneous_write();
        cpu_ren = 1; cpu_wen = 1; cpu_addr = 16'h0040; cpu_wdata = 16'hAAAA;
        dev_req = 1; dev_we = 1; dev_byt = 1; dev_addr = 16'h0004; dev_wdata = 16'h00DF;
        @(negedge clk);
        checks++; if ({mem_ren, mem_wen} !== 2'b01) begin errors++; $display("FAIL sw_cpu_en actual=%b expected=01", {mem_ren, mem_wen}); end
        checks++; if (mem_addr !== 16'h0040 || mem_wdata !== 16'hAAAA || dev_gnt !== 1'b0) begin errors++; $display("FAIL sw_cpu actual=%h/%h/%b expected=0040/aaaa/0", mem_addr, mem_wdata, dev_gnt); end
        tick(); cpu_ren = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;
        @(negedge clk);
        checks++; if (dev_gnt !== 1'b1 || mem_wen !== 1'b1 || mem_ren !== 1'b0) begin errors++; $display("FAIL sw_dev_en actual=%b/%b/%b expected=1/1/0", dev_gnt, mem_wen, mem_ren); end
        checks++; if (mem_addr !== 16'h0004 || mem_wdata !== 16'h00DF || mem_byt !== 1'b1) begin errors++; $display("FAIL sw_dev actual=%h/%h/%b expected=0004/00df/1", mem_addr, mem_wdata, mem_byt); end
        tick(); idle_inputs();
        @(negedge clk);
        checks++; if ({mem_ren, mem_wen, mem_byt} !== 3'b000 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin errors++; $display("FAIL sw_idle actual=%b/%h/%h expected=000/0000/0000", {mem_ren, mem_wen, mem_byt}, mem_addr, mem_wdata); end
        checks++; if (dev_rvalid !== 1'b0) begin errors++; $display("FAIL sw_rvalid actual=%b expected=0", dev_rvalid); end
        tick();
        $display("txn simultaneous_write: dev 0004<=00df");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1;
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_contention();
        test_starvation();
        test_interleaved();
        test_reset_mid_read();
        test_simultaneous_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
